// File: rtl/soc_spi_flash_pkg.sv
// Shared constants, state type and opcode decode for the SPI flash read front end.
// SPI_FLASH_FAST_READ_EN: when defined, opcode 0x0B (FAST_READ) decodes as a read with dummy cycles.
package soc_spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int unsigned ADDR_PHASE_BITS = 24;
  localparam int unsigned DUMMY_BITS      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_STATUS,
    ST_IGNORE
  } spi_fe_state_t;

  function automatic spi_fe_state_t decode_opcode(input logic [7:0] op);
    spi_fe_state_t nxt;
    case (op)
      CMD_READ:      nxt = ST_ADDR;
      CMD_RDSR:      nxt = ST_STATUS;
`ifdef SPI_FLASH_FAST_READ_EN
      CMD_FAST_READ: nxt = ST_ADDR;
`endif
      default:       nxt = ST_IGNORE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises ss/sck/mosi into clk and produces single-cycle edge pulses.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss,
  input  logic sck,
  input  logic mosi,
  output logic ss_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise
);

  logic [SYNC_STAGES-1:0] ss_q, ss_d;
  logic [SYNC_STAGES-1:0] sck_q, sck_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   sck_s;

  always_comb begin
    ss_d       = {ss_q[SYNC_STAGES-2:0], ss};
    sck_d      = {sck_q[SYNC_STAGES-2:0], sck};
    mosi_d     = {mosi_q[SYNC_STAGES-2:0], mosi};
    ss_prev_d  = ss_s;
    sck_prev_d = sck_s;
  end

  // Chains reset to 0 so an ss already low at reset release never looks like a falling edge;
  // the front end only arms after ss has actually been seen high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_q       <= '0;
      sck_q      <= '0;
      mosi_q     <= '0;
      ss_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_prev_q  <= ss_prev_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  assign ss_s     = ss_q[SYNC_STAGES-1];
  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;

endmodule

// File: rtl/spi_flash_read_frontend.sv
// SPI mode-0 slave front end for the boot flash model: READ/RDSR decode, byte fetch with prefetch.
// SPI_FLASH_FAST_READ_EN: enables FAST_READ (0x0B) with 8 dummy cycles (decode lives in the package).
module spi_flash_read_frontend
  import soc_spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [4:0] ADDR_LAST  = 5'(ADDR_PHASE_BITS - 1);
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);

  logic ss_s, mosi_s, sck_rise, sck_fall, ss_fall, ss_rise;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ss      (ss),
    .sck     (sck),
    .mosi    (mosi),
    .ss_s    (ss_s),
    .mosi_s  (mosi_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .ss_fall (ss_fall),
    .ss_rise (ss_rise)
  );

  spi_fe_state_t     state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        pre_q, pre_d;
  logic              fast_q, fast_d;
  logic              req_q, req_d;
  logic              rd_pend_q, rd_pend_d;
  logic              cmd_err_q, cmd_err_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;
  logic [23:0]       shift_in;
  spi_fe_state_t     op_next;

  assign shift_in = {shift_q[22:0], mosi_s};
  assign op_next  = decode_opcode(shift_in[7:0]);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    pre_d     = rd_pend_q ? mem_rdata : pre_q;
    fast_d    = fast_q;
    req_d     = 1'b0;
    rd_pend_d = req_q;
    cmd_err_d = 1'b0;
    miso_d    = miso_q;
    busy_d    = ~ss_s;

    if (ss_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (ss_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 5'd7) begin
              state_d   = op_next;
              bit_cnt_d = '0;
              fast_d    = (shift_in[7:0] == CMD_FAST_READ);
              cmd_err_d = (op_next == ST_IGNORE);
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == ADDR_LAST) begin
              addr_d    = shift_in[ADDR_W-1:0];
              req_d     = 1'b1;
              bit_cnt_d = '0;
              state_d   = fast_q ? ST_DUMMY : ST_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_DUMMY: begin
          miso_d = 1'b0;
          if (sck_rise) begin
            if (bit_cnt_q == DUMMY_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          // Byte start: present the prefetched byte and fetch the next address behind it.
          if (sck_fall) begin
            if (bit_cnt_q == '0) begin
              tx_d   = pre_q;
              miso_d = pre_q[7];
              addr_d = addr_q + ADDR_W'(1);
              req_d  = 1'b1;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              miso_d = tx_q[6];
            end
            bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
          end
        end
        ST_STATUS: miso_d = 1'b0;
        ST_IGNORE: miso_d = 1'b0;
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      pre_q     <= '0;
      fast_q    <= 1'b0;
      req_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      cmd_err_q <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      pre_q     <= pre_d;
      fast_q    <= fast_d;
      req_q     <= req_d;
      rd_pend_q <= rd_pend_d;
      cmd_err_q <= cmd_err_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
    end
  end

  assign miso     = miso_q;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_read_frontend.sv
// Directed bench for spi_flash_read_frontend; storage model returns addr[7:0]^0xA5 one clk after mem_req.
module tb_spi_flash_read_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso, mem_req, busy, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned err_pulses = 0;
  logic [23:0] req_log[$];
  logic [7:0]  rx[8];

  always #5 clk = ~clk;

  spi_flash_read_frontend #(
    .ADDR_W     (24),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always @(posedge clk) if (mem_req) mem_rdata <= mem_addr[7:0] ^ 8'hA5;

  always @(negedge clk) begin
    if (mem_req) req_log.push_back(mem_addr);
    if (cmd_err) err_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: sck low + mosi setup, sample miso just before the rising edge, then hold high.
  task automatic spi_bit(input logic b, output logic r);
    sck  = 1'b0;
    mosi = b;
    wait_clk(4);
    r   = miso;
    sck = 1'b1;
    wait_clk(4);
  endtask

  task automatic spi_byte(input logic [7:0] o, output logic [7:0] i);
    logic r;
    for (int k = 7; k >= 0; k--) begin
      spi_bit(o[k], r);
      i[k] = r;
    end
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    wait_clk(4);
  endtask

  task automatic ss_end();
    ss = 1'b1;
    wait_clk(4);
    sck  = 1'b0;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic do_txn(input logic [7:0] op, input logic [23:0] a, input int ndummy, input int n);
    logic [7:0] junk;
    ss_begin();
    spi_byte(op, junk);
    spi_byte(a[23:16], junk);
    spi_byte(a[15:8], junk);
    spi_byte(a[7:0], junk);
    for (int d = 0; d < ndummy; d++) spi_byte(8'h00, junk);
    for (int j = 0; j < 8; j++) rx[j] = 8'h00;
    for (int j = 0; j < n; j++) spi_byte(8'h00, rx[j]);
    chk("busy_in_txn", {31'd0, busy}, 32'd1);
    ss_end();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int e0;
    logic [7:0] junk;
    logic r;

    // 1: reset with ss low and sck toggling; then ss still low must not arm the slave.
    ss = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sck = ~sck;
      @(negedge clk);
      chk("reset_outs", {28'd0, miso, mem_req, busy, cmd_err}, 32'd0);
    end
    sck = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    base = req_log.size();
    e0 = err_pulses;
    spi_byte(8'h03, junk);
    spi_byte(8'h00, junk);
    spi_byte(8'h00, junk);
    spi_byte(8'h10, junk);
    spi_byte(8'h00, rx[0]);
    chk("noarm_req", req_log.size() - base, 32'd0);
    chk("noarm_miso", {24'd0, rx[0]}, 32'd0);
    chk("noarm_err", err_pulses - e0, 32'd0);
    ss_end();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 2: READ 0x000010, 4 bytes.
    base = req_log.size();
    do_txn(8'h03, 24'h000010, 0, 4);
    chk("rd_b0", {24'd0, rx[0]}, 32'hB5);
    chk("rd_b1", {24'd0, rx[1]}, 32'hB4);
    chk("rd_b2", {24'd0, rx[2]}, 32'hB7);
    chk("rd_b3", {24'd0, rx[3]}, 32'hB6);
    chk("rd_nreq", req_log.size() - base, 32'd5);
    for (int k = 0; k < 5; k++)
      if (base + k < req_log.size())
        chk("rd_addr", {8'd0, req_log[base+k]}, 32'h10 + k);
    chk("rd_busy_after", {31'd0, busy}, 32'd0);
    chk("rd_miso_after", {31'd0, miso}, 32'd0);

    // 3: wrap at top of address space.
    base = req_log.size();
    do_txn(8'h03, 24'hFFFFFE, 0, 3);
    chk("wr_b0", {24'd0, rx[0]}, 32'h5B);
    chk("wr_b1", {24'd0, rx[1]}, 32'h5A);
    chk("wr_b2", {24'd0, rx[2]}, 32'hA5);
    chk("wr_nreq", req_log.size() - base, 32'd4);
    if (req_log.size() - base >= 3) begin
      chk("wr_a1", {8'd0, req_log[base+1]}, 32'hFFFFFF);
      chk("wr_a2", {8'd0, req_log[base+2]}, 32'h000000);
    end

    // 4: abort after 12 address bits, then a clean read of address 0.
    base = req_log.size();
    ss_begin();
    spi_byte(8'h03, junk);
    spi_byte(8'h00, junk);
    for (int k = 0; k < 4; k++) spi_bit(1'b0, r);
    ss_end();
    chk("abort_nreq", req_log.size() - base, 32'd0);
    do_txn(8'h03, 24'h000000, 0, 1);
    chk("abort_next_b0", {24'd0, rx[0]}, 32'hA5);

    // 5: unsupported opcode, then RDSR.
    base = req_log.size();
    e0 = err_pulses;
    ss_begin();
    spi_byte(8'h9F, junk);
    for (int j = 0; j < 4; j++) spi_byte(8'h5A, rx[j]);
    ss_end();
    chk("bad_err", err_pulses - e0, 32'd1);
    chk("bad_miso", {rx[0], rx[1], rx[2], rx[3]}, 32'd0);
    chk("bad_nreq", req_log.size() - base, 32'd0);
    ss_begin();
    spi_byte(8'h05, junk);
    spi_byte(8'h00, rx[0]);
    spi_byte(8'h00, rx[1]);
    ss_end();
    chk("rdsr", {16'd0, rx[0], rx[1]}, 32'd0);
    chk("rdsr_err", err_pulses - e0, 32'd1);
    chk("rdsr_nreq", req_log.size() - base, 32'd0);

    // 6: FAST_READ.
    base = req_log.size();
    e0 = err_pulses;
    do_txn(8'h0B, 24'h000020, 1, 2);
`ifdef SPI_FLASH_FAST_READ_EN
    chk("fr_b0", {24'd0, rx[0]}, 32'h85);
    chk("fr_b1", {24'd0, rx[1]}, 32'h84);
    chk("fr_nreq", req_log.size() - base, 32'd3);
    if (req_log.size() > base) chk("fr_a0", {8'd0, req_log[base]}, 32'h20);
    chk("fr_err", err_pulses - e0, 32'd0);
`else
    chk("fr_err", err_pulses - e0, 32'd1);
    chk("fr_miso", {16'd0, rx[0], rx[1]}, 32'd0);
    chk("fr_nreq", req_log.size() - base, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
